// File: rtl/alu_bit_serial_seq.sv
// Bit-serial sequencer around a single ALU_1_bit slice: streams operands LSB-first,
// chains the carry through a register and reassembles F bits into a WIDTH-bit result.
module alu_bit_serial_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic [1:0]       op_mode,
  output logic             accept_ok,
  output logic             busy,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_m0,
  output logic             slice_m1,
  input  logic             slice_f,
  input  logic             slice_cout,
  input  logic             slice_n,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             result_n,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [1:0]       mode;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // busy is exactly "state == RUN", so it gates the data-path outputs outside RUN
  assign slice_a   = busy & a_sh[0];
  assign slice_b   = busy & b_sh[0];
  assign slice_cin = busy & carry;
  assign slice_m0  = mode[0];
  assign slice_m1  = mode[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      mode        <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      result_n    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      accept_ok   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh      <= op_a;
            b_sh      <= op_b;
            mode      <= op_mode;
            carry     <= op_cin;
            cnt       <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            accept_ok <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= slice_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {slice_f, acc[WIDTH-1:1]};
          if (cnt == LAST) begin
            result      <= {slice_f, acc[WIDTH-1:1]};
            result_cout <= slice_cout;
            result_n    <= slice_n;
            done        <= 1'b1;
            busy        <= 1'b0;
            accept_ok   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          accept_ok <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Self-checking bench: behavioural ALU_1_bit slice model plus a word-level reference
// (plain add / logic ops) for the sequencer's assembled result.
module tb_alu_bit_serial_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         op_cin;
  logic [1:0]   op_mode;
  logic         accept_ok, busy;
  logic         slice_a, slice_b, slice_cin, slice_m0, slice_m1;
  logic         slice_f, slice_cout, slice_n;
  logic [W-1:0] result;
  logic         result_cout, result_n, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_bit_serial_seq #(.WIDTH(W), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .op_cin(op_cin), .op_mode(op_mode), .accept_ok(accept_ok), .busy(busy),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_m0(slice_m0), .slice_m1(slice_m1), .slice_f(slice_f),
    .slice_cout(slice_cout), .slice_n(slice_n), .result(result),
    .result_cout(result_cout), .result_n(result_n), .done(done)
  );

  // Slice model: 00 AND, 01 full adder, 10 OR, 11 XOR; N mirrors F.
  always_comb begin
    slice_cout = 1'b0;
    case ({slice_m1, slice_m0})
      2'b00: slice_f = slice_a & slice_b;
      2'b01: begin
        slice_f    = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      end
      2'b10: slice_f = slice_a | slice_b;
      default: slice_f = slice_a ^ slice_b;
    endcase
    slice_n = slice_f;
  end

  // Word-level reference: {n, cout, result}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic [1:0] m);
    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (m)
      2'b00: r = a & b;
      2'b01: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r   = sum[W-1:0];
        c   = sum[W];
      end
      2'b10: r = a | b;
      default: r = a ^ b;
    endcase
    return {r[W-1], c, r};
  endfunction

  // Caller is at a negedge. Returns cycles from accept to done (20 = timed out),
  // number of busy cycles seen and the slice_cin value of each RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [1:0] m, output int lat, output int busy_cnt,
                        output logic [W-1:0] cin_trace);
    op_a = a; op_b = b; op_cin = cin; op_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0; cin_trace = '0;
    while (!done && lat < 20) begin
      if (busy) begin
        if (busy_cnt < W) cin_trace[busy_cnt] = slice_cin;
        busy_cnt++;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({result, result_cout, result_n, done, busy, accept_ok} !== {{W{1'b0}}, 5'b00001}) begin
      failures++;
      $display("FAIL reset_outputs: got res=%b cout=%b n=%b done=%b busy=%b acc=%b",
               result, result_cout, result_n, done, busy, accept_ok);
    end
    checks++;
    if ({slice_a, slice_b, slice_cin, slice_m0, slice_m1} !== 5'b0) begin
      failures++;
      $display("FAIL reset_slice: got %b%b%b%b%b want 00000",
               slice_a, slice_b, slice_cin, slice_m0, slice_m1);
    end
  endtask

  task automatic test_add();
    int lat, bc; logic [W-1:0] tr;
    run_op(4'b0101, 4'b0011, 1'b0, 2'b01, lat, bc, tr);
    checks++;
    if (lat != W + 1 || bc != W) begin
      failures++; $display("FAIL add_latency: got lat=%0d busy=%0d want %0d/%0d", lat, bc, W + 1, W);
    end
    checks++;
    if ({result, result_cout} !== 5'b1000_0) begin
      failures++; $display("FAIL add_result: got %b/%b want 1000/0", result, result_cout);
    end
  endtask

  task automatic test_carry_ripple();
    int lat, bc; logic [W-1:0] tr;
    run_op(4'b1111, 4'b0001, 1'b0, 2'b01, lat, bc, tr);
    checks++;
    if ({result, result_cout} !== 5'b0000_1) begin
      failures++; $display("FAIL ripple_result: got %b/%b want 0000/1", result, result_cout);
    end
    checks++;
    if (tr !== 4'b1110) begin
      failures++; $display("FAIL ripple_cin_trace: got %b want 1110 (bit i = RUN cycle i)", tr);
    end
  endtask

  task automatic test_cin_hold();
    int lat, bc; logic [W-1:0] tr;
    run_op(4'b0000, 4'b0000, 1'b1, 2'b01, lat, bc, tr);
    checks++;
    if ({result, result_cout} !== 5'b0001_0) begin
      failures++; $display("FAIL cin_result: got %b/%b want 0001/0", result, result_cout);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (result !== 4'b0001 || done !== 1'b0 || accept_ok !== 1'b1) begin
        failures++;
        $display("FAIL hold_cycle%0d: got res=%b done=%b acc=%b want 0001/0/1", i, result, done, accept_ok);
      end
    end
  endtask

  task automatic test_busy_guard();
    int pulses = 0;
    op_a = 4'b0101; op_b = 4'b0011; op_cin = 1'b0; op_mode = 2'b01; start = 1'b1;
    @(negedge clk);
    op_a = 4'b1111; op_b = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        checks++;
        if (result !== 4'b1000) begin
          failures++; $display("FAIL guard_result: got %b want 1000", result);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL guard_done_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    op_a = 4'b0010; op_b = 4'b0010; op_cin = 1'b0; op_mode = 2'b01; start = 1'b1;
    @(negedge clk);
    op_a = 4'b0111; op_b = 4'b0001;
    k = 1;
    while (!done && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k != W + 1 || result !== 4'b0100) begin
      failures++; $display("FAIL b2b_first: got lat=%0d res=%b want %0d/0100", k, result, W + 1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL b2b_accept_in_done: got busy=%b want 1", busy);
    end
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k != W + 1 || result !== 4'b1000) begin
      failures++; $display("FAIL b2b_second: got lat=%0d res=%b want %0d/1000", k, result, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses; logic [W-1:0] tr;
    op_a = 4'b1111; op_b = 4'b0001; op_cin = 1'b0; op_mode = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, accept_ok, done, result, result_cout} !== {3'b010, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b acc=%b done=%b res=%b cout=%b want 0/1/0/0000/0",
               busy, accept_ok, done, result, result_cout);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    run_op(4'b0001, 4'b0001, 1'b0, 2'b01, lat, bc, tr);
    checks++;
    if (result !== 4'b0010 || lat != W + 1) begin
      failures++; $display("FAIL abort_recover: got res=%b lat=%0d want 0010/%0d", result, lat, W + 1);
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [W-1:0] tr, a, b; logic c; logic [1:0] m; logic [W+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom); m = 2'($urandom);
      if (i < 10) m = 2'b01;
      exp = ref_op(a, b, c, m);
      run_op(a, b, c, m, lat, bc, tr);
      checks++;
      if ({result_n, result_cout, result} !== exp || lat != W + 1) begin
        failures++;
        $display("FAIL rand%0d a=%b b=%b cin=%b m=%b: got n/c/res=%b lat=%0d want %b lat=%0d",
                 i, a, b, c, m, {result_n, result_cout, result}, lat, exp, W + 1);
      end
      checks++;
      if ({slice_m1, slice_m0} !== m || {slice_a, slice_b, slice_cin} !== 3'b000) begin
        failures++;
        $display("FAIL rand%0d_idle_slice: got m=%b%b abc=%b%b%b want m=%b abc=000",
                 i, slice_m1, slice_m0, slice_a, slice_b, slice_cin, m);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_mode = 2'b00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add();
    @(negedge clk);
    test_carry_ripple();
    @(negedge clk);
    test_cin_hold();
    test_busy_guard();
    test_back_to_back();
    test_reset_abort();
    @(negedge clk);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
